spi_secondary_mode: RTL and testbench
=====================================

Name: spi_secondary_mode

Overview:
- Generalised SPI secondary (slave) front end.
- Features: parametrised word width; runtime-selectable SPI mode 0-3 (CPOL/CPHA); MSB- or LSB-first framing; active-low chip select with proper frame start/abort; multi-word frames.
- Adds input synchronisers and edge detection, so SPI pins can come straight from FPGA I/O.
- Sits between the SPI pads and the command/step-data decoder; presents a one-cycle-strobed word interface on the clk domain.

Parameters:
- WordBits, 8, bits per word; legal range 2..32.
- SyncStages, 2, synchroniser flops on sck, cs_n and in_bit; minimum 2.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  reset, asynchronous, active-low.
- sck  input  1  SPI clock from main, asynchronous to clk.
- cs_n  input  1  chip select, active-low, asynchronous.
- in_bit  input  1  main-out/secondary-in data.
- out_bit  output  1  main-in/secondary-out data.
- out_en  output  1  pad output enable; high while the synchronised cs_n is low.
- mode  input  2  {CPOL,CPHA}; latched at frame start.
- msb_first  input  1  1 = MSB first, 0 = LSB first; latched at frame start.
- tx_data  input  WordBits  next word to transmit; sampled when tx_load is high.
- tx_load  output  1  one-cycle pulse: tx_data captured this cycle.
- rx_data  output  WordBits  last complete received word; held until the next word completes.
- rx_valid  output  1  one-cycle pulse: rx_data updated.
- rx_abort  output  1  one-cycle pulse: frame ended with a partial word.
- busy  output  1  frame in progress.

Behaviour:
- Reset (rst_n low, asynchronous): out_bit 0, out_en 0, tx_load 0, rx_data 0, rx_valid 0, rx_abort 0, busy 0, bit counter 0. Synchronisers reset as follows: sck to 0, cs_n to 1, in_bit to 0. Reset mid-frame discards everything; the next frame starts only on a fresh cs_n falling edge after reset release.
- Synchronisation: sck, cs_n and in_bit each pass SyncStages flops, plus one history flop for edge detection. Each sck phase must last at least SyncStages+2 clk cycles; faster sck is unsupported.
- Edge classes: with the latched mode, sample edge = rising if CPOL==CPHA, else falling; shift edge = the opposite edge.
- States: IDLE, ACTIVE.
- IDLE -> ACTIVE on synchronised cs_n falling edge. In that cycle:
  - latch mode and msb_first;
  - pulse tx_load and load tx_data into the tx shift register;
  - clear the bit counter;
  - if CPHA=0, drive out_bit with the first bit (tx_data[WordBits-1] if msb_first, else tx_data[0]) and shift it out of the register;
  - an sck edge detected in this same cycle is ignored.
- ACTIVE, sample edge:
  - shift the synchronised in_bit into the rx register (msb_first: enters at LSB, shifts left; else enters at MSB, shifts right);
  - increment the counter.
  - When the counter reaches WordBits: on the next cycle rx_data takes the assembled word and rx_valid pulses. In the same cycle, tx_load pulses, tx_data reloads the tx shift register and the counter returns to 0.
  - Total latency from the external sample edge to rx_valid is SyncStages+2 clk cycles.
- ACTIVE, shift edge: out_bit <= next bit from the tx shift register, in the latched order. After a word boundary, the first shift edge emits the next word's first bit.
- Edge counts:
  - CPHA=1: the first shift edge (the leading edge) emits bit 0.
  - CPHA=0: exactly WordBits-1 shift edges are meaningful per word, plus one boundary shift edge that emits the next word's first bit.
- ACTIVE -> IDLE on synchronised cs_n rising edge:
  - if the counter is nonzero, pulse rx_abort and discard the partial word (rx_valid does not pulse);
  - clear the counter;
  - out_en drops in the same cycle, out_bit holds its value.
  - If word completion and cs_n rise land in the same cycle, completion wins: rx_valid and tx_load pulse, rx_abort does not.
- sck edges in IDLE are ignored. mode/msb_first changes during ACTIVE have no effect until the next frame.
- busy = ACTIVE. Multi-word frames are unlimited.
- rx_data has no backpressure: a consumer that misses an rx_valid pulse loses that word.

Decomposition:
- Package spi_pkg:
  - spi_mode_e enum (MODE0..MODE3 = 2'b00..2'b11);
  - function sample_on_rising(mode) = (mode[1]==mode[0]);
  - state enum spi_state_e {IDLE, ACTIVE}.
- Sub-module spi_sync_edge (parameter SyncStages):
  - one instance per input, or a width-parameterised version;
  - outputs the synchronised level plus rise and fall strobes;
  - reused by future SPI blocks.

Test Plan:
- Mode 0, MSB first, tx_data=0xA5, main sends 0x3C over 8 clocks. Required: main receives 0xA5; rx_valid pulses once with rx_data=0x3C; tx_load pulses at cs_n fall and at word end.
- Mode 3, LSB first, 2-word frame with tx words 0x81 then 0x7E, main sends 0x12, 0x34. Required: main receives 0x81, 0x7E; rx_valid twice with 0x12 then 0x34; tx_load 3 pulses.
- Modes 1 and 2, WordBits=12, tx 0xABC, main sends 0x5A5. Required: main receives 0xABC; rx_data=0x5A5. Also check out_bit changes only on shift edges.
- Abort: cs_n rises after 5 bits. Required: rx_abort pulses once; no rx_valid; rx_data keeps its prior value; the next full frame in mode 0 works.
- Async reset mid-word (bit 4), then a full frame 0xC3. Required: all outputs 0 during reset; the first rx_valid carries 0xC3.
- sck toggles with cs_n high, and mode changes mid-frame. Required: no rx_valid, no tx_load, busy 0 while idle; the mid-frame mode change is ignored and the word is received correctly.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI front-end blocks.
package spi_pkg;

    typedef enum logic [1:0] {
        MODE0 = 2'b00,
        MODE1 = 2'b01,
        MODE2 = 2'b10,
        MODE3 = 2'b11
    } spi_mode_e;

    typedef enum logic {
        IDLE,
        ACTIVE
    } spi_state_e;

    // mode is {CPOL, CPHA}: data is sampled on the rising sck edge when they match.
    function automatic logic sample_on_rising(input logic [1:0] mode);
        return mode[1] == mode[0];
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous pin, with a history flop for edge strobes.
module spi_sync_edge #(
    parameter int unsigned SyncStages = 2,
    parameter logic        ResetVal   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SyncStages-1:0] sync_q;
    logic                  hist_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SyncStages{ResetVal}};
            hist_q <= ResetVal;
        end else begin
            sync_q <= {sync_q[SyncStages-2:0], din};
            hist_q <= sync_q[SyncStages-1];
        end
    end

    assign level = sync_q[SyncStages-1];
    assign rise  = level & ~hist_q;
    assign fall  = ~level & hist_q;

endmodule

// File: rtl/spi_secondary_mode.sv
// SPI secondary front end: modes 0-3, MSB/LSB-first, multi-word frames, word-strobe interface.
module spi_secondary_mode
    import spi_pkg::*;
#(
    parameter int unsigned WordBits   = 8,
    parameter int unsigned SyncStages = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sck,
    input  logic                cs_n,
    input  logic                in_bit,
    output logic                out_bit,
    output logic                out_en,
    input  logic [1:0]          mode,
    input  logic                msb_first,
    input  logic [WordBits-1:0] tx_data,
    output logic                tx_load,
    output logic [WordBits-1:0] rx_data,
    output logic                rx_valid,
    output logic                rx_abort,
    output logic                busy
);

    localparam int unsigned     CntW    = $clog2(WordBits + 1);
    localparam logic [CntW-1:0] CntFull = CntW'(WordBits);

    logic sck_level, sck_rise, sck_fall;
    logic cs_level, cs_rise, cs_fall;
    logic in_level, in_rise, in_fall;

    spi_sync_edge #(.SyncStages(SyncStages), .ResetVal(1'b0)) u_sync_sck (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (sck),
        .level (sck_level),
        .rise  (sck_rise),
        .fall  (sck_fall)
    );

    spi_sync_edge #(.SyncStages(SyncStages), .ResetVal(1'b1)) u_sync_cs (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (cs_n),
        .level (cs_level),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    spi_sync_edge #(.SyncStages(SyncStages), .ResetVal(1'b0)) u_sync_in (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (in_bit),
        .level (in_level),
        .rise  (in_rise),
        .fall  (in_fall)
    );

    logic unused_sync;
    assign unused_sync = ^{sck_level, cs_level, in_rise, in_fall};

    spi_state_e          state_q;
    spi_mode_e           mode_q;
    logic                msb_q;
    logic [CntW-1:0]     cnt_q;
    logic [WordBits-1:0] tx_sh_q;
    logic [WordBits-1:0] rx_sh_q;

    logic samp_rising, sample_edge, shift_edge;

    assign samp_rising = sample_on_rising(mode_q);
    assign sample_edge = samp_rising ? sck_rise : sck_fall;
    assign shift_edge  = samp_rising ? sck_fall : sck_rise;

    assign busy   = (state_q == ACTIVE);
    assign out_en = (state_q == ACTIVE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            mode_q   <= MODE0;
            msb_q    <= 1'b1;
            cnt_q    <= '0;
            tx_sh_q  <= '0;
            rx_sh_q  <= '0;
            out_bit  <= 1'b0;
            tx_load  <= 1'b0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            rx_abort <= 1'b0;
        end else begin
            tx_load  <= 1'b0;
            rx_valid <= 1'b0;
            rx_abort <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (cs_fall) begin
                        state_q <= ACTIVE;
                        mode_q  <= spi_mode_e'(mode);
                        msb_q   <= msb_first;
                        cnt_q   <= '0;
                        tx_load <= 1'b1;
                        // CPHA=0 has no leading shift edge, so the first bit goes out now.
                        if (!mode[0]) begin
                            out_bit <= msb_first ? tx_data[WordBits-1] : tx_data[0];
                            tx_sh_q <= msb_first ? (tx_data << 1) : (tx_data >> 1);
                        end else begin
                            tx_sh_q <= tx_data;
                        end
                    end
                end
                ACTIVE: begin
                    if (cnt_q == CntFull) begin
                        // Completion beats a simultaneous cs_n rise.
                        rx_data  <= rx_sh_q;
                        rx_valid <= 1'b1;
                        tx_load  <= 1'b1;
                        tx_sh_q  <= tx_data;
                        cnt_q    <= '0;
                        if (cs_rise) begin
                            state_q <= IDLE;
                        end
                    end else if (cs_rise) begin
                        state_q  <= IDLE;
                        rx_abort <= (cnt_q != '0);
                        cnt_q    <= '0;
                    end else begin
                        if (sample_edge) begin
                            rx_sh_q <= msb_q ? {rx_sh_q[WordBits-2:0], in_level}
                                             : {in_level, rx_sh_q[WordBits-1:1]};
                            cnt_q   <= cnt_q + CntW'(1);
                        end
                        if (shift_edge) begin
                            out_bit <= msb_q ? tx_sh_q[WordBits-1] : tx_sh_q[0];
                            tx_sh_q <= msb_q ? (tx_sh_q << 1) : (tx_sh_q >> 1);
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_secondary_mode.sv
// Bench for spi_secondary_mode: an 8-bit and a 12-bit instance driven by a behavioural SPI main.
module tb_spi_secondary_mode;

    localparam int HALF = 60;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sck = 1'b0;
    logic        cs8 = 1'b1;
    logic        cs12 = 1'b1;
    logic        in_bit = 1'b0;
    logic        msb_first = 1'b1;
    logic [1:0]  mode = 2'b00;
    logic [11:0] tx_bus = '0;

    logic        ob8, oe8, tl8, rv8, ra8, bz8;
    logic [7:0]  rd8;
    logic        ob12, oe12, tl12, rv12, ra12, bz12;
    logic [11:0] rd12;

    always #5 clk = ~clk;

    spi_secondary_mode #(.WordBits(8), .SyncStages(2)) u_dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .sck       (sck),
        .cs_n      (cs8),
        .in_bit    (in_bit),
        .out_bit   (ob8),
        .out_en    (oe8),
        .mode      (mode),
        .msb_first (msb_first),
        .tx_data   (tx_bus[7:0]),
        .tx_load   (tl8),
        .rx_data   (rd8),
        .rx_valid  (rv8),
        .rx_abort  (ra8),
        .busy      (bz8)
    );

    spi_secondary_mode #(.WordBits(12), .SyncStages(2)) u_dut12 (
        .clk       (clk),
        .rst_n     (rst_n),
        .sck       (sck),
        .cs_n      (cs12),
        .in_bit    (in_bit),
        .out_bit   (ob12),
        .out_en    (oe12),
        .mode      (mode),
        .msb_first (msb_first),
        .tx_data   (tx_bus),
        .tx_load   (tl12),
        .rx_data   (rd12),
        .rx_valid  (rv12),
        .rx_abort  (ra12),
        .busy      (bz12)
    );

    int checks = 0;
    int errors = 0;

    int nrv[2];
    int ntl[2];
    int nab[2];
    logic [31:0] rxq0[$];
    logic [31:0] rxq1[$];

    logic        sel_g = 1'b0;
    logic        miso;
    assign miso = sel_g ? ob12 : ob8;

    logic [31:0] tx_words[0:4];
    logic [31:0] mosi_words[0:3];
    logic [31:0] miso_words[0:3];
    bit          stable_ok;

    always @(negedge clk) begin
        if (rv8) begin
            nrv[0]++;
            rxq0.push_back({24'b0, rd8});
        end
        if (rv12) begin
            nrv[1]++;
            rxq1.push_back({20'b0, rd12});
        end
        if (tl8)  ntl[0]++;
        if (tl12) ntl[1]++;
        if (ra8)  nab[0]++;
        if (ra12) nab[1]++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mask(input int w);
        return (32'h1 << w) - 32'h1;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, ":dut8"},  {18'b0, ob8, oe8, tl8, rv8, ra8, bz8, rd8}, 32'h0);
        check({tag, ":dut12"}, {14'b0, ob12, oe12, tl12, rv12, ra12, bz12, rd12}, 32'h0);
    endtask

    // Behavioural SPI main: CPHA=0 presents data before the leading edge, CPHA=1 on it.
    task automatic xfer(input bit sel, input logic [1:0] m, input bit msb, input int nbits,
                        input bit finish, input bit glitch);
        int   w;
        logic s;
        w = sel ? 12 : 8;
        sel_g = sel;
        mode = m;
        msb_first = msb;
        tx_bus = tx_words[0][11:0];
        sck = m[1];
        for (int k = 0; k < 4; k++) miso_words[k] = '0;
        stable_ok = 1'b1;
        #(HALF);
        if (sel) cs12 = 1'b0; else cs8 = 1'b0;
        #(HALF);
        for (int b = 0; b < nbits; b++) begin
            int k, i, bi;
            k = b / w;
            i = b % w;
            bi = msb ? (w - 1 - i) : i;
            if (m[0]) sck = ~sck;
            in_bit = mosi_words[k][bi];
            #(HALF);
            sck = ~sck;
            s = miso;
            miso_words[k][bi] = s;
            if (i == 0) tx_bus = tx_words[k + 1][11:0];
            if (glitch && b == 2) begin
                mode = ~m;
                msb_first = ~msb;
            end
            #(HALF - 1);
            if (miso !== s) stable_ok = 1'b0;
            #1;
            if (!m[0]) sck = ~sck;
        end
        #(HALF);
        if (finish) begin
            cs8 = 1'b1;
            cs12 = 1'b1;
            #(2 * HALF);
        end
    endtask

    task automatic run_frame(input string tag, input bit sel, input logic [1:0] m,
                             input bit msb, input int nwords, input bit glitch);
        int          w, v0, t0, a0;
        logic [31:0] got;
        w = sel ? 12 : 8;
        v0 = nrv[sel];
        t0 = ntl[sel];
        a0 = nab[sel];
        if (sel) rxq1.delete(); else rxq0.delete();
        xfer(sel, m, msb, nwords * w, 1'b1, glitch);
        check({tag, ":busy"}, sel ? bz12 : bz8, 32'h0);
        check({tag, ":rx_valid_cnt"}, nrv[sel] - v0, nwords);
        check({tag, ":tx_load_cnt"}, ntl[sel] - t0, nwords + 1);
        check({tag, ":abort_cnt"}, nab[sel] - a0, 32'h0);
        check({tag, ":obit_stable"}, stable_ok, 32'h1);
        for (int k = 0; k < nwords; k++) begin
            check({tag, ":miso"}, miso_words[k] & mask(w), tx_words[k] & mask(w));
            got = '1;
            if (sel) begin
                if (rxq1.size() > 0) got = rxq1.pop_front();
            end else begin
                if (rxq0.size() > 0) got = rxq0.pop_front();
            end
            check({tag, ":rx_word"}, got, mosi_words[k] & mask(w));
        end
    endtask

    initial begin
        int v0, t0, a0, v1, t1;
        for (int k = 0; k < 5; k++) tx_words[k] = '0;
        for (int k = 0; k < 4; k++) mosi_words[k] = '0;

        #23;
        check_all_zero("in_reset");
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #2;
        check_all_zero("after_reset");

        // Mode 0, MSB first
        tx_words[0] = 32'hA5;
        tx_words[1] = $urandom & 32'hFF;
        mosi_words[0] = 32'h3C;
        run_frame("mode0", 1'b0, 2'd0, 1'b1, 1, 1'b0);

        // Mode 3, LSB first, two words
        tx_words[0] = 32'h81;
        tx_words[1] = 32'h7E;
        tx_words[2] = $urandom & 32'hFF;
        mosi_words[0] = 32'h12;
        mosi_words[1] = 32'h34;
        run_frame("mode3", 1'b0, 2'd3, 1'b0, 2, 1'b0);

        // Modes 1 and 2 on the 12-bit instance
        tx_words[0] = 32'hABC;
        tx_words[1] = $urandom & 32'hFFF;
        mosi_words[0] = 32'h5A5;
        run_frame("mode1_w12", 1'b1, 2'd1, 1'b1, 1, 1'b0);
        run_frame("mode2_w12", 1'b1, 2'd2, 1'b0, 1, 1'b0);

        // Abort after 5 bits
        tx_words[0] = 32'h5A;
        mosi_words[0] = 32'hFF;
        v0 = nrv[0];
        t0 = ntl[0];
        a0 = nab[0];
        xfer(1'b0, 2'd0, 1'b1, 5, 1'b1, 1'b0);
        check("abort:abort_cnt", nab[0] - a0, 32'h1);
        check("abort:rx_valid_cnt", nrv[0] - v0, 32'h0);
        check("abort:tx_load_cnt", ntl[0] - t0, 32'h1);
        check("abort:rx_data_held", {24'b0, rd8}, 32'h34);
        tx_words[0] = 32'h96;
        mosi_words[0] = 32'h69;
        run_frame("post_abort", 1'b0, 2'd0, 1'b1, 1, 1'b0);

        // Asynchronous reset at bit 4 of a word
        tx_words[0] = 32'h0F;
        mosi_words[0] = 32'hFF;
        xfer(1'b0, 2'd0, 1'b1, 4, 1'b0, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        repeat (3) @(posedge clk);
        cs8 = 1'b1;
        #7;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #2;
        tx_words[0] = $urandom & 32'hFF;
        tx_words[1] = $urandom & 32'hFF;
        mosi_words[0] = 32'hC3;
        run_frame("post_reset", 1'b0, 2'd0, 1'b1, 1, 1'b0);

        // sck activity while both chip selects are high
        v0 = nrv[0];
        t0 = ntl[0];
        v1 = nrv[1];
        t1 = ntl[1];
        for (int n = 0; n < 10; n++) begin
            #(HALF);
            sck = ~sck;
        end
        #(HALF);
        check("idle:rx_valid_cnt", (nrv[0] - v0) + (nrv[1] - v1), 32'h0);
        check("idle:tx_load_cnt", (ntl[0] - t0) + (ntl[1] - t1), 32'h0);
        check("idle:busy", {30'b0, bz8, bz12}, 32'h0);
        sck = 1'b0;
        #(HALF);

        // Mode and bit order changed mid-frame
        tx_words[0] = 32'hE7;
        tx_words[1] = $urandom & 32'hFF;
        mosi_words[0] = 32'h4B;
        run_frame("mode_glitch", 1'b0, 2'd0, 1'b1, 1, 1'b1);

        for (int r = 0; r < 6; r++) begin
            bit         sel, msb;
            logic [1:0] m;
            int         nw;
            sel = 1'($urandom_range(0, 1));
            m = 2'($urandom_range(0, 3));
            msb = 1'($urandom_range(0, 1));
            nw = $urandom_range(1, 3);
            for (int k = 0; k < 5; k++) tx_words[k] = $urandom & 32'hFFF;
            for (int k = 0; k < 4; k++) mosi_words[k] = $urandom & 32'hFFF;
            run_frame("random", sel, m, msb, nw, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
